// File: rtl/led_pkg.sv
// Shared definitions for the rotating LED pattern controller.
package led_pkg;

   localparam int LED_W = 12;
   localparam logic [LED_W-1:0] BASE_PATTERN = 12'b000011101101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } led_state_t;

   typedef logic [1:0] speed_t;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every 2^(TICK_LOG2-speed) enabled cycles.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_LOG2 = 24
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   input  logic   clr,
   input  speed_t speed,
   output logic   tick
);

   logic [TICK_LOG2-1:0] cnt;
   logic [TICK_LOG2-1:0] limit;

   // period-1 is an all-ones mask narrowed by the speed select
   assign limit = {TICK_LOG2{1'b1}} >> speed;
   assign tick  = en && (cnt == limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + TICK_LOG2'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Rotating LED pattern controller with run/pause, one-shot revolution and a ready/valid config port.
module led_pattern_ctrl #(
   parameter int                 LED_W        = led_pkg::LED_W,
   parameter logic [LED_W-1:0]   BASE_PATTERN = led_pkg::BASE_PATTERN,
   parameter int                 TICK_LOG2    = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [LED_W-1:0]      cfg_pattern,
   input  logic                  cfg_dir,
   input  led_pkg::speed_t       cfg_speed,
   input  logic                  cfg_oneshot,
   input  logic                  run,
   output logic [LED_W-1:0]      led,
   output logic [3:0]            step,
   output logic                  done
);

   import led_pkg::*;

   led_state_t       state, state_nxt;
   logic [LED_W-1:0] pattern, pattern_nxt;
   logic             dir;
   speed_t           speed;
   logic             oneshot;
   logic             xfer;
   logic             tick;
   logic             presc_en;
   logic             presc_clr;
   logic             wrap_done;
   logic [3:0]       step_adv;
   logic [3:0]       step_nxt;

   function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] p, input logic [3:0] s);
      return (p << s) | (p >> (LED_W - int'(s)));
   endfunction

   assign cfg_ready = (state == S_IDLE) || (state == S_PAUSE);
   assign xfer      = cfg_valid && cfg_ready;

   always_comb begin
      if (!dir) begin
         step_adv = (step == 4'(LED_W - 1)) ? 4'd0 : step + 4'd1;
      end else begin
         step_adv = (step == 4'd0) ? 4'(LED_W - 1) : step - 4'd1;
      end
   end

   // A transfer always clears the prescaler, even when it coincides with a run edge
   always_comb begin
      state_nxt = state;
      presc_en  = 1'b0;
      presc_clr = xfer;
      wrap_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_RUN;
               presc_clr = 1'b1;
            end
         end
         S_RUN: begin
            presc_en = 1'b1;
            if (tick && oneshot && (step_adv == 4'd0)) begin
               state_nxt = S_DONE;
               wrap_done = 1'b1;
            end else if (!run) begin
               state_nxt = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (run) state_nxt = S_RUN;
         end
         S_DONE: begin
            if (!run) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign pattern_nxt = xfer ? cfg_pattern : pattern;
   assign step_nxt    = xfer ? 4'd0 : ((presc_en && tick) ? step_adv : step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // led is recomputed from the next-cycle pattern/step so both change on one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= BASE_PATTERN;
         dir     <= 1'b0;
         speed   <= '0;
         oneshot <= 1'b0;
         step    <= 4'd0;
         led     <= BASE_PATTERN;
         done    <= 1'b0;
      end else begin
         if (xfer) begin
            pattern <= cfg_pattern;
            dir     <= cfg_dir;
            speed   <= cfg_speed;
            oneshot <= cfg_oneshot;
         end
         step <= step_nxt;
         led  <= rotl(pattern_nxt, step_nxt);
         done <= wrap_done;
      end
   end

   led_tick_gen #(
      .TICK_LOG2(TICK_LOG2)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (presc_en),
      .clr   (presc_clr),
      .speed (speed),
      .tick  (tick)
   );

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: cycle model checked every negedge plus directed literal checks.
module tb_led_pattern_ctrl;

   localparam int LW = 12;
   localparam int TL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [11:0] cfg_pattern = 12'h000;
   logic        cfg_dir = 1'b0;
   logic [1:0]  cfg_speed = 2'd0;
   logic        cfg_oneshot = 1'b0;
   logic        run = 1'b0;
   logic [11:0] led;
   logic [3:0]  step;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   led_pattern_ctrl #(
      .LED_W        (LW),
      .BASE_PATTERN (12'b000011101101),
      .TICK_LOG2    (TL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_dir     (cfg_dir),
      .cfg_speed   (cfg_speed),
      .cfg_oneshot (cfg_oneshot),
      .run         (run),
      .led         (led),
      .step        (step),
      .done        (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] rot_model(input logic [11:0] p, input int s);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < LW; i++) r[(i + s) % LW] = p[i];
      return r;
   endfunction

   // Model: mode 0 idle, 1 run, 2 pause, 3 done; elapsed = run cycles since last restart
   int          m_mode, m_dir, m_speed, m_oneshot, m_step, m_elapsed;
   logic [11:0] m_pat;
   logic        m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_pat = 12'h0ED; m_dir = 0; m_speed = 0; m_oneshot = 0;
         m_step = 0; m_elapsed = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (cfg_valid && (m_mode == 0 || m_mode == 2)) begin
            m_pat = cfg_pattern; m_dir = int'(cfg_dir); m_speed = int'(cfg_speed);
            m_oneshot = int'(cfg_oneshot); m_step = 0; m_elapsed = 0;
         end
         case (m_mode)
            0: if (run) begin m_mode = 1; m_elapsed = 0; end
            1: begin
               m_elapsed++;
               if (m_elapsed == (1 << (TL - m_speed))) begin
                  m_elapsed = 0;
                  m_step = (m_step + (m_dir != 0 ? LW - 1 : 1)) % LW;
                  if (m_oneshot != 0 && m_step == 0) begin
                     m_mode = 3;
                     m_done = 1'b1;
                  end
               end
               if (m_mode == 1 && !run) m_mode = 2;
            end
            2: if (run) m_mode = 1;
            default: if (!run) m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("model_led", led, rot_model(m_pat, m_step));
      check("model_step", step, m_step);
      check("model_done", done, m_done);
      check("model_ready", cfg_ready, (m_mode == 0 || m_mode == 2));
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      // reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_led", led, 12'h0ED);
      check("rst_step", step, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_done", done, 0);
      rst_n = 1'b1;

      // free-running rotation at speed 0, with an ignored config offer mid-run
      @(negedge clk); run = 1'b1;
      repeat (16) @(negedge clk);
      check("pre_first_tick_led", led, 12'h0ED);
      @(negedge clk);
      check("first_tick_led", led, 12'h1DA);
      check("first_tick_step", step, 1);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_pattern = 12'hFFF; cfg_dir = 1'b1; cfg_speed = 2'd3;
      repeat (3) @(negedge clk);
      check("run_ready_low", cfg_ready, 0);
      cfg_valid = 1'b0; cfg_pattern = 12'h000; cfg_dir = 1'b0; cfg_speed = 2'd0;
      repeat (12) @(negedge clk);
      check("step2_led", led, 12'h3B4);
      check("step2_step", step, 2);
      repeat (160) @(negedge clk);
      check("rev_led", led, 12'h0ED);
      check("rev_step", step, 0);
      check("rev_no_done", done_cnt, 0);
      run = 1'b0;
      @(negedge clk);
      check("pause_ready", cfg_ready, 1);

      // one-shot reverse revolution at speed 3
      cfg_valid = 1'b1; cfg_pattern = 12'h001; cfg_dir = 1'b1; cfg_speed = 2'd3; cfg_oneshot = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("load_led", led, 12'h001);
      check("load_step", step, 0);
      run = 1'b1;
      repeat (2) @(negedge clk);
      check("os_pre_led", led, 12'h001);
      @(negedge clk);
      check("os_first_led", led, 12'h800);
      check("os_first_step", step, 11);
      repeat (21) @(negedge clk);
      check("os_no_done_yet", done, 0);
      @(negedge clk);
      check("os_done", done, 1);
      check("os_done_led", led, 12'h001);
      check("os_done_step", step, 0);
      check("os_done_ready", cfg_ready, 0);
      @(negedge clk);
      check("os_done_pulse_end", done, 0);
      repeat (3) @(negedge clk);
      check("os_done_once", done_cnt, 1);
      run = 1'b0;
      @(negedge clk);
      check("back_idle_ready", cfg_ready, 1);

      // transfer coinciding with run, then pause/resume keeps the prescaler
      cfg_valid = 1'b1; cfg_pattern = 12'h0ED; cfg_dir = 1'b0; cfg_speed = 2'd0; cfg_oneshot = 1'b0;
      run = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("xfer_run_led", led, 12'h0ED);
      check("xfer_run_ready", cfg_ready, 0);
      repeat (4) @(negedge clk);
      run = 1'b0;
      check("pre_pause_ready", cfg_ready, 0);
      @(negedge clk);
      check("paused_ready", cfg_ready, 1);
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         check("paused_hold_ready", cfg_ready, 1);
      end
      run = 1'b1;
      repeat (11) @(negedge clk);
      check("resume_pre_step", step, 0);
      check("resume_ready", cfg_ready, 0);
      @(negedge clk);
      check("resume_tick_step", step, 1);
      check("resume_tick_led", led, 12'h1DA);

      // asynchronous reset mid-run at step 7
      for (int i = 0; i < 200 && step != 4'd7; i++) @(negedge clk);
      check("reach_step7", step, 7);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_led", led, 12'h0ED);
      check("async_rst_step", step, 0);
      check("async_rst_done", done, 0);
      check("async_rst_ready", cfg_ready, 1);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_done_after_rst", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 12, LED bank width.
REQ-002 SHALL have parameter BASE_PATTERN, default 12'b000011101101, pattern loaded at reset.
REQ-003 SHALL have parameter TICK_LOG2, default 24, log2 of the step period at speed 0.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  input  1  configuration offer.
REQ-007 SHALL have port cfg_ready  output  1  configuration acceptance.
REQ-008 SHALL have port cfg_pattern  input  LED_W  new base pattern.
REQ-009 SHALL have port cfg_dir  input  1  direction: 0 = rotate left (step up), 1 = rotate right (step down).
REQ-010 SHALL have port cfg_speed  input  2  speed select; step period = 2^(TICK_LOG2-cfg_speed) cycles.
REQ-011 SHALL have port cfg_oneshot  input  1  1 = stop after one full revolution.
REQ-012 SHALL have port run  input  1  level-sensitive run/pause request.
REQ-013 SHALL have port led  output  LED_W  registered LED drive.
REQ-014 SHALL have port step  output  4  current rotation index, 0..LED_W-1.
REQ-015 SHALL have port done  output  1  one-cycle pulse at one-shot completion.

Function
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 SHALL drive led = base pattern rotated left by step at all times; led and step SHALL update on the same edge.
REQ-018 SHALL assert cfg_ready only in IDLE and PAUSE; a transfer SHALL occur on an edge with cfg_valid && cfg_ready.
REQ-019 On a transfer: latch pattern, dir, speed, oneshot; set step to 0; clear the prescaler.
REQ-020 cfg_valid outside IDLE/PAUSE SHALL be ignored, with no change to stored configuration.
REQ-021 Transitions: IDLE->RUN when run=1, clearing the prescaler; RUN->PAUSE when run=0; PAUSE->RUN when run=1, keeping the prescaler value; DONE->IDLE when run=0.
REQ-022 A transfer and a run-driven transition on the same edge SHALL both take effect, with the prescaler cleared.
REQ-023 The prescaler SHALL count only in RUN and SHALL hold its value in PAUSE.
REQ-024 A tick SHALL occur when prescaler == period-1; on a tick the prescaler SHALL return to 0.
REQ-025 On a tick, step SHALL wrap modulo LED_W: dir=0 gives 11->0; dir=1 gives 0->11.
REQ-026 If oneshot=1 and a tick makes step 0, the block SHALL enter DONE and assert done for exactly that next cycle.
REQ-027 In DONE, step SHALL be 0 and led SHALL hold the base pattern.
REQ-028 In IDLE, DONE and PAUSE, led and step SHALL hold their values.

Reset
REQ-029 While rst_n=0, outputs SHALL be reset immediately, independent of clk.
REQ-030 Reset values: state IDLE, pattern BASE_PATTERN, dir 0, speed 0, oneshot 0, step 0, led BASE_PATTERN, prescaler 0, done 0, cfg_ready 1.
REQ-031 Reset asserted mid-RUN SHALL abandon the revolution; no done pulse SHALL be produced.

Structure
REQ-032 The shared package led_pkg SHALL hold LED_W, the BASE_PATTERN default, the state enum, and the 2-bit speed type.
REQ-033 The prescaler SHALL be a sub-module, led_tick_gen, with ports: en, clr, speed, tick.
REQ-034 The implementation SHALL be 120-400 RTL lines with no latches; led SHALL be fully registered.

Verification (TICK_LOG2=4: periods 16/8/4/2)
REQ-035 Reset -> led=0x0ED, step=0, cfg_ready=1, done=0.
REQ-036 run=1 at speed 0 -> led=0x1DA, step=1, 16 cycles after RUN entry; after 12 ticks led=0x0ED, step=0, with no done pulse.
REQ-037 Load 0x001 with dir=1, speed=3, oneshot=1, then run=1 -> led=0x800 after 2 cycles; done pulses once after 24 cycles; DONE with led=0x001; run=0 returns to IDLE.
REQ-038 Speed 0: run=0 after 5 RUN cycles, hold 20 cycles, run=1 -> next tick exactly 11 cycles after resume; cfg_ready=1 only during the pause.
REQ-039 cfg_valid with 0xFFF during RUN -> cfg_ready=0; pattern and rotation unchanged.
REQ-040 rst_n low mid-RUN at step 7 -> led=0x0ED and step=0 before the next clk edge; no done pulse.
